// File: rtl/apb_test_regfile_pkg.sv
// ----------------------------------------------------------------------------
// apb_test_regfile_pkg
// Shared definitions for the APB bring-up register file:
//   - word-index constants of the register map (index = PADDR[W-1:2])
//   - CTRL field positions
//   - state type of the wait-state sequencer
// ----------------------------------------------------------------------------
package apb_test_regfile_pkg;

    // Word indices of the fixed registers; scratch words follow contiguously.
    localparam int SIGNATURE_IDX    = 0;
    localparam int CTRL_IDX         = 1;
    localparam int WCOUNT_IDX       = 2;
    localparam int SCRATCH_BASE_IDX = 3;

    // CTRL layout: WAIT occupies [wait_w-1:0], ERR_EN sits directly above it.
    localparam int CTRL_WAIT_LSB = 0;

    // Bit position of CTRL.ERR_EN for a given WAIT field width.
    function automatic int ctrl_err_en_bit(input int wait_w);
        return CTRL_WAIT_LSB + wait_w;
    endfunction

    // Number of implemented CTRL bits (WAIT field plus ERR_EN).
    function automatic int ctrl_width(input int wait_w);
        return wait_w + 1;
    endfunction

    // Wait-state sequencer state.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } wait_state_e;

endpackage : apb_test_regfile_pkg

// File: rtl/apb_wait_fsm.sv
// ----------------------------------------------------------------------------
// apb_wait_fsm
// Stretches APB transfers by a programmable number of wait states and
// detects a master abandoning a stretched transfer.
//
// Ports:
//   HCLK      in   clock
//   HRESETn   in   asynchronous active-low reset
//   access    in   PSEL & PENABLE (APB access phase)
//   wait_w    in   wait states for this transfer, sampled in the first access cycle
//   psel      in   slave select, used to detect an abort while stretching
//   complete  out  transfer completes this cycle (drives PREADY)
//   abort     out  PSEL was dropped while a transfer was being stretched
//
// A transfer with wait_w = W whose first access cycle is N completes in cycle
// N+W: for W=0 directly from IDLE, otherwise from WAIT when the counter,
// loaded with W in cycle N and decremented every cycle, has reached 1.
// ----------------------------------------------------------------------------
module apb_wait_fsm
    import apb_test_regfile_pkg::*;
#(
    parameter int MAX_WAIT_W = 4
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  access,
    input  logic [MAX_WAIT_W-1:0] wait_w,
    input  logic                  psel,
    output logic                  complete,
    output logic                  abort
);

    localparam logic [MAX_WAIT_W-1:0] CNT_ZERO = MAX_WAIT_W'(0);
    localparam logic [MAX_WAIT_W-1:0] CNT_ONE  = MAX_WAIT_W'(1);

    wait_state_e           state_r;
    logic [MAX_WAIT_W-1:0] cnt_r;
    logic                  last_s;

    // Counter value 1 in WAIT marks the final wait cycle.
    assign last_s = (state_r == WAIT) && (cnt_r == CNT_ONE);

    // Completion and abort decode from the registered state.
    always_comb begin
        complete = 1'b0;
        abort    = 1'b0;
        case (state_r)
            IDLE: begin
                complete = access && (wait_w == CNT_ZERO);
                abort    = 1'b0;
            end
            WAIT: begin
                complete = access && last_s;
                abort    = !psel;
            end
            default: begin
                complete = 1'b0;
                abort    = 1'b0;
            end
        endcase
    end

    // State and wait counter sequencing.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            case (state_r)
                IDLE: begin
                    if (access && (wait_w != CNT_ZERO)) begin
                        state_r <= WAIT;
                        cnt_r   <= wait_w;
                    end else begin
                        state_r <= IDLE;
                        cnt_r   <= CNT_ZERO;
                    end
                end
                WAIT: begin
                    if (!psel) begin
                        // Master walked away: drop the transfer.
                        state_r <= IDLE;
                        cnt_r   <= CNT_ZERO;
                    end else if (last_s && access) begin
                        state_r <= IDLE;
                        cnt_r   <= CNT_ZERO;
                    end else if (cnt_r > CNT_ONE) begin
                        state_r <= WAIT;
                        cnt_r   <= cnt_r - CNT_ONE;
                    end else begin
                        // Final wait cycle without PENABLE: hold until it returns.
                        state_r <= WAIT;
                        cnt_r   <= cnt_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= CNT_ZERO;
                end
            endcase
        end
    end

endmodule : apb_wait_fsm

// File: rtl/apb_test_regfile.sv
// ----------------------------------------------------------------------------
// apb_test_regfile
// APB3 slave for bring-up: read-only SIGNATURE, CTRL (wait states + error
// enable), WCOUNT (counts committed writes, cleared by writing it) and
// NUM_SCRATCH read/write scratch words.
//
// Ports:
//   HCLK     in   clock
//   HRESETn  in   asynchronous active-low reset
//   PADDR    in   byte address, word index = PADDR[APB_ADDR_WIDTH-1:2]
//   PWDATA   in   write data
//   PWRITE   in   1 = write
//   PSEL     in   slave select
//   PENABLE  in   access phase
//   PRDATA   out  read data, non-zero only in the completing cycle of a good read
//   PREADY   out  transfer complete
//   PSLVERR  out  error response (unmapped access or SIGNATURE write, ERR_EN=1)
//
// Register updates commit on the clock edge that ends the PREADY=1 cycle.
// The response of a CTRL write uses the CTRL value that was in place before it.
// ----------------------------------------------------------------------------
module apb_test_regfile
    import apb_test_regfile_pkg::*;
#(
    parameter int          APB_ADDR_WIDTH = 12,
    parameter int          NUM_SCRATCH    = 4,
    parameter logic [31:0] SIGNATURE      = 32'h00DA41DE,
    parameter int          MAX_WAIT_W     = 4
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR
);

    localparam int IDX_W      = APB_ADDR_WIDTH - 2;
    localparam int CTRL_W     = ctrl_width(MAX_WAIT_W);
    localparam int ERR_EN_BIT = ctrl_err_en_bit(MAX_WAIT_W);

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [CTRL_W-1:0] ctrl_r;
    logic [31:0]       wcount_r;
    logic [31:0]       scratch_r [NUM_SCRATCH];

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]       idx_s;
    logic                   access_s;
    logic                   hit_sig_s;
    logic                   hit_ctrl_s;
    logic                   hit_wcount_s;
    logic [NUM_SCRATCH-1:0] scratch_sel_s;
    logic                   hit_scratch_s;
    logic                   mapped_s;
    logic                   err_s;
    logic [31:0]            rdata_s;
    logic [MAX_WAIT_W-1:0]  wait_w_s;
    logic                   err_en_s;
    logic                   complete_s;
    logic                   abort_s;
    logic                   ready_s;
    logic                   commit_s;
    logic                   unused_s;

    // Byte-lane bits carry no meaning for a word-only register file.
    assign unused_s = ^PADDR[1:0];

    assign idx_s    = PADDR[APB_ADDR_WIDTH-1:2];
    assign access_s = PSEL & PENABLE;
    assign wait_w_s = ctrl_r[CTRL_WAIT_LSB +: MAX_WAIT_W];
    assign err_en_s = ctrl_r[ERR_EN_BIT];

    assign hit_sig_s    = (idx_s == IDX_W'(SIGNATURE_IDX));
    assign hit_ctrl_s   = (idx_s == IDX_W'(CTRL_IDX));
    assign hit_wcount_s = (idx_s == IDX_W'(WCOUNT_IDX));

    // One-hot select of the addressed scratch word.
    always_comb begin
        scratch_sel_s = '0;
        for (int i = 0; i < NUM_SCRATCH; i++) begin
            scratch_sel_s[i] = (idx_s == IDX_W'(SCRATCH_BASE_IDX + i));
        end
    end

    assign hit_scratch_s = |scratch_sel_s;
    assign mapped_s      = hit_sig_s | hit_ctrl_s | hit_wcount_s | hit_scratch_s;

    // SIGNATURE is read-only, so writing it is treated like an unmapped access.
    assign err_s = ~mapped_s | (PWRITE & hit_sig_s);

    // Read mux; unmapped indices fall through to zero.
    always_comb begin
        rdata_s = 32'h0000_0000;
        if (hit_sig_s) begin
            rdata_s = SIGNATURE;
        end else if (hit_ctrl_s) begin
            rdata_s = {{(32-CTRL_W){1'b0}}, ctrl_r};
        end else if (hit_wcount_s) begin
            rdata_s = wcount_r;
        end else begin
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                rdata_s = rdata_s | (scratch_sel_s[i] ? scratch_r[i] : 32'h0000_0000);
            end
        end
    end

    // ------------------------------------------------------------------
    // Wait-state sequencing
    // ------------------------------------------------------------------
    apb_wait_fsm #(
        .MAX_WAIT_W (MAX_WAIT_W)
    ) u_wait_fsm (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .access   (access_s),
        .wait_w   (wait_w_s),
        .psel     (PSEL),
        .complete (complete_s),
        .abort    (abort_s)
    );

    // An aborted transfer never completes, even on its last counted cycle.
    assign ready_s  = complete_s & ~abort_s;
    assign commit_s = ready_s & PWRITE & ~err_s;

    // ------------------------------------------------------------------
    // Response
    // ------------------------------------------------------------------
    assign PREADY  = ready_s;
    assign PSLVERR = ready_s & err_s & err_en_s;
    assign PRDATA  = (ready_s & ~PWRITE & ~err_s) ? rdata_s : 32'h0000_0000;

    // ------------------------------------------------------------------
    // Register updates
    // ------------------------------------------------------------------

    // CTRL and WCOUNT: CTRL/scratch writes count, a WCOUNT write clears.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ctrl_r   <= '0;
            wcount_r <= 32'h0000_0000;
        end else if (commit_s) begin
            if (hit_ctrl_s) begin
                ctrl_r   <= PWDATA[CTRL_W-1:0];
                wcount_r <= wcount_r + 32'd1;
            end else if (hit_wcount_s) begin
                ctrl_r   <= ctrl_r;
                wcount_r <= 32'h0000_0000;
            end else if (hit_scratch_s) begin
                ctrl_r   <= ctrl_r;
                wcount_r <= wcount_r + 32'd1;
            end else begin
                ctrl_r   <= ctrl_r;
                wcount_r <= wcount_r;
            end
        end else begin
            ctrl_r   <= ctrl_r;
            wcount_r <= wcount_r;
        end
    end

    // Scratch words: plain storage written on a committed hit.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                scratch_r[i] <= 32'h0000_0000;
            end
        end else begin
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                if (commit_s && scratch_sel_s[i]) begin
                    scratch_r[i] <= PWDATA;
                end else begin
                    scratch_r[i] <= scratch_r[i];
                end
            end
        end
    end

endmodule : apb_test_regfile

// File: tb/tb_apb_test_regfile.sv
// ----------------------------------------------------------------------------
// tb_apb_test_regfile
// Self-checking bench for apb_test_regfile: directed scenarios followed by
// randomized APB traffic, all checked against a register-level model.
// ----------------------------------------------------------------------------
module tb_apb_test_regfile;

    localparam int          AW   = 12;
    localparam int          NS   = 4;
    localparam logic [31:0] SIG  = 32'h00DA41DE;
    localparam int          MWW  = 4;

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic [AW-1:0] PADDR;
    logic [31:0]   PWDATA;
    logic          PWRITE;
    logic          PSEL;
    logic          PENABLE;
    logic [31:0]   PRDATA;
    logic          PREADY;
    logic          PSLVERR;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [4:0]  m_ctrl;
    logic [31:0] m_wcount;
    logic [31:0] m_scr [NS];

    apb_test_regfile #(
        .APB_ADDR_WIDTH (AW),
        .NUM_SCRATCH    (NS),
        .SIGNATURE      (SIG),
        .MAX_WAIT_W     (MWW)
    ) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PWRITE  (PWRITE),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ctrl   = 5'd0;
        m_wcount = 32'd0;
        for (int i = 0; i < NS; i++) m_scr[i] = 32'd0;
    endtask

    // One APB transfer. drop_k >= 0 drops PSEL in cycle N+drop_k.
    task automatic apb_xfer(input logic [AW-1:0] addr, input logic [31:0] wdata,
                            input logic wr, input int drop_k, output logic [31:0] rd);
        int          idx;
        int          exp_w;
        logic        exp_err;
        logic [31:0] exp_rd;
        logic        exp_abort;
        int          cyc;
        logic        got;
        logic        aborted;
        logic        err;

        // Expected response from the register map rules
        idx     = int'(addr[AW-1:2]);
        exp_w   = int'(m_ctrl[3:0]);
        exp_err = (idx >= 3 + NS) || (wr && idx == 0);
        if (idx == 0)            exp_rd = SIG;
        else if (idx == 1)       exp_rd = {27'd0, m_ctrl};
        else if (idx == 2)       exp_rd = m_wcount;
        else if (idx < 3 + NS)   exp_rd = m_scr[idx - 3];
        else                     exp_rd = 32'd0;
        if (wr || exp_err) exp_rd = 32'd0;
        exp_abort = (drop_k >= 0) && (drop_k <= exp_w);

        @(posedge HCLK); #1;
        PADDR = addr; PWDATA = wdata; PWRITE = wr; PSEL = 1'b1; PENABLE = 1'b0;
        @(negedge HCLK);
        chk("setup_pready", {31'd0, PREADY}, 32'd0);
        @(posedge HCLK); #1;
        PENABLE = 1'b1;

        cyc = 0; got = 1'b0; aborted = 1'b0; rd = 32'd0; err = 1'b0;
        while (!got && !aborted && cyc <= 40) begin
            @(negedge HCLK);
            if (!PSEL) begin
                chk("abort_pready", {31'd0, PREADY}, 32'd0);
                aborted = 1'b1;
            end else if (PREADY) begin
                got = 1'b1;
                rd  = PRDATA;
                err = PSLVERR;
            end else begin
                chk("wait_prdata", PRDATA, 32'd0);
                cyc++;
                @(posedge HCLK); #1;
                if (cyc == drop_k) begin
                    PSEL = 1'b0; PENABLE = 1'b0;
                end
            end
        end
        if (!got && !aborted) chk("timeout", 32'd1, 32'd0);

        chk("aborted", {31'd0, aborted}, {31'd0, exp_abort});
        if (got) begin
            @(posedge HCLK); #1;
            PSEL = 1'b0; PENABLE = 1'b0;
            chk("latency", cyc, exp_w);
            chk("prdata", rd, exp_rd);
            chk("pslverr", {31'd0, err}, {31'd0, exp_err & m_ctrl[4]});
            // Commit into the model
            if (wr && !exp_err) begin
                if (idx == 1) begin
                    m_ctrl = wdata[4:0];
                    m_wcount++;
                end else if (idx == 2) begin
                    m_wcount = 32'd0;
                end else begin
                    m_scr[idx - 3] = wdata;
                    m_wcount++;
                end
            end
        end
    endtask

    logic [31:0] rd;
    logic [31:0] rnd_data;
    logic [AW-1:0] rnd_addr;
    int drop;

    initial begin
        HRESETn = 1'b0;
        PADDR = '0; PWDATA = 32'd0; PWRITE = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
        model_reset();
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        chk("rst_pready", {31'd0, PREADY}, 32'd0);
        chk("rst_prdata", PRDATA, 32'd0);
        chk("rst_pslverr", {31'd0, PSLVERR}, 32'd0);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;

        // Signature and CTRL after reset
        apb_xfer(12'h000, 32'd0, 1'b0, -1, rd);
        chk("sig_value", rd, 32'h00DA41DE);
        apb_xfer(12'h004, 32'd0, 1'b0, -1, rd);
        chk("ctrl_reset", rd, 32'd0);

        // Scratch write/readback and WCOUNT
        apb_xfer(12'h00C, 32'hCAFEF00D, 1'b1, -1, rd);
        apb_xfer(12'h00C, 32'd0, 1'b0, -1, rd);
        chk("scratch0", rd, 32'hCAFEF00D);
        apb_xfer(12'h008, 32'd0, 1'b0, -1, rd);
        chk("wcount1", rd, 32'd1);
        for (int i = 1; i < NS; i++) apb_xfer(AW'(12 + 4 * i), 32'd0, 1'b0, -1, rd);

        // Wait states take effect from the next transfer
        apb_xfer(12'h004, 32'h3, 1'b1, -1, rd);
        apb_xfer(12'h00C, 32'd0, 1'b0, -1, rd);

        // Error reporting with ERR_EN
        apb_xfer(12'h004, 32'h13, 1'b1, -1, rd);
        apb_xfer(12'h000, 32'h1234, 1'b1, -1, rd);
        apb_xfer(AW'(12 + 4 * NS), 32'd0, 1'b0, -1, rd);
        apb_xfer(12'h000, 32'd0, 1'b0, -1, rd);
        chk("sig_kept", rd, 32'h00DA41DE);
        apb_xfer(12'h008, 32'd0, 1'b0, -1, rd);
        chk("wcount3", rd, 32'd3);

        // Abort with W=5
        apb_xfer(12'h004, 32'h5, 1'b1, -1, rd);
        apb_xfer(12'h010, 32'hFFFFFFFF, 1'b1, 2, rd);
        apb_xfer(12'h010, 32'd0, 1'b0, -1, rd);
        chk("scratch1_kept", rd, 32'd0);
        apb_xfer(12'h008, 32'd0, 1'b0, -1, rd);

        // Reset in the middle of a W=3 write
        apb_xfer(12'h004, 32'h3, 1'b1, -1, rd);
        @(posedge HCLK); #1;
        PADDR = 12'h010; PWDATA = 32'h5555AAAA; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
        @(posedge HCLK); #1;
        PENABLE = 1'b1;
        @(posedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
        #1;
        chk("midrst_pready", {31'd0, PREADY}, 32'd0);
        chk("midrst_prdata", PRDATA, 32'd0);
        repeat (2) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        model_reset();
        apb_xfer(12'h004, 32'd0, 1'b0, -1, rd);
        chk("ctrl_after_rst", rd, 32'd0);
        apb_xfer(12'h010, 32'd0, 1'b0, -1, rd);
        apb_xfer(12'h00C, 32'd0, 1'b0, -1, rd);
        apb_xfer(12'h008, 32'd0, 1'b0, -1, rd);

        // Randomized traffic
        for (int t = 0; t < 300; t++) begin
            rnd_addr = AW'({$urandom_range(0, 3 + NS + 2), 2'($urandom_range(0, 3))});
            rnd_data = $urandom;
            drop = -1;
            if (m_ctrl[3:0] != 4'd0 && $urandom_range(0, 9) == 0)
                drop = $urandom_range(1, int'(m_ctrl[3:0]));
            apb_xfer(rnd_addr, rnd_data, 1'($urandom_range(0, 1)), drop, rd);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_apb_test_regfile

// File: doc/apb_test_regfile.md
Name: apb_test_regfile

Overview:
- Parametrised APB3 slave for bring-up and teaching: a read-only signature, a control register, a write counter, and NUM_SCRATCH R/W scratch words.
- Adds programmable wait states (PREADY stretching), optional PSLVERR reporting, and transfer-abort handling.
- Sits on the SoC peripheral APB bus as one 4 KB slave, alongside the other peripheral slaves.

Parameters:
- APB_ADDR_WIDTH, 12, PADDR width; word index = PADDR[APB_ADDR_WIDTH-1:2]; PADDR[1:0] ignored.
- NUM_SCRATCH, 4, number of 32-bit scratch registers; range 1 to 2^(APB_ADDR_WIDTH-2)-3.
- SIGNATURE, 32'hDA41DE, value returned by the SIGNATURE register.
- MAX_WAIT_W, 4, width of the CTRL.WAIT field; maximum wait states = 2^MAX_WAIT_W-1.

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  asynchronous active-low reset
- PADDR  in  APB_ADDR_WIDTH  byte address
- PWDATA  in  32  write data
- PWRITE  in  1  1=write
- PSEL  in  1  slave select
- PENABLE  in  1  access phase
- PRDATA  out  32  read data
- PREADY  out  1  transfer complete
- PSLVERR  out  1  error response

Behaviour:
- Reset: HRESETn, asynchronous, active-low; clock HCLK.
  - Reset values: CTRL=0, WCOUNT=0, all scratch=0, FSM=IDLE, PRDATA=0, PREADY=0, PSLVERR=0.
- Register map (word offsets):
  - 0x00 SIGNATURE: RO, reads SIGNATURE.
  - 0x04 CTRL: RW. [MAX_WAIT_W-1:0] = WAIT; [MAX_WAIT_W] = ERR_EN; other bits read 0.
  - 0x08 WCOUNT: RO count; any write clears it to 0.
  - 0x0C + 4*i: SCRATCH[i], RW, for i < NUM_SCRATCH.
  - Any other word index is unmapped.
- Access phase = PSEL & PENABLE. Let N be the first access cycle and W the CTRL.WAIT value sampled in cycle N.
  - W is captured in N; a CTRL write changes wait states from the next transfer only.
- FSM states: IDLE, WAIT.
  - IDLE: access with W=0 → PREADY=1 in cycle N, stay IDLE. Access with W>0 → load counter=W, go WAIT, PREADY=0.
  - WAIT: counter decrements each cycle. PREADY=1 in cycle N+W (counter==1), then return to IDLE.
  - Back-to-back transfers are legal: a new access phase after completion starts a fresh count.
- PSEL deasserted while in WAIT: abort. Return to IDLE next cycle, no register side effect, WCOUNT unchanged.
- Register updates commit on the rising edge ending the PREADY=1 cycle.
- PRDATA/PSLVERR are driven only in the PREADY=1 cycle; otherwise 0.
  - PRDATA on reads only; 0 on writes and on errors.
- Error condition: unmapped address (read or write), or write to SIGNATURE.
  - ERR_EN=1: PSLVERR=1 with PREADY; the write is ignored.
  - ERR_EN=0: PSLVERR=0; unmapped reads return 0; the write is ignored.
- WCOUNT increments by 1, wrapping modulo 2^32, on each committed error-free write to CTRL or SCRATCH.
  - Writes to WCOUNT clear it and are not counted.
  - A write to CTRL itself uses the old WAIT/ERR_EN for its own response.
- Reset asserted mid-transfer: FSM immediately IDLE, all registers to reset values, no commit.

Decomposition:
- Package apb_test_regfile_pkg holds:
  - word-index constants: SIGNATURE_IDX=0, CTRL_IDX=1, WCOUNT_IDX=2, SCRATCH_BASE_IDX=3;
  - CTRL field position constants;
  - typedef enum {IDLE, WAIT} for the FSM state.
- One sub-module, apb_wait_fsm: takes access, W and PSEL; outputs complete (PREADY) and abort; holds the state and counter.
- Register decode, storage and read mux stay in the top module.

Test Plan:
- Reset, then read 0x00 and 0x04 with W=0 → PREADY in cycle N, PRDATA=0x00DA41DE then 0x0; PSLVERR=0.
- Write 0xCAFEF00D to 0x0C, read it back, then read 0x08 → 0xCAFEF00D, then WCOUNT=1; all other scratch words read 0.
- Write CTRL=0x3 (W=3), then read 0x0C → PREADY=0 in N..N+2 and 1 in N+3 with correct data; the CTRL write itself completes with 0 waits.
- Write CTRL=0x13 (ERR_EN, W=3), then write 0x00 with 0x1234, then read unmapped 0x0C+4*NUM_SCRATCH:
  - both → PSLVERR=1 with PREADY at N+3, PRDATA=0;
  - SIGNATURE unchanged, WCOUNT unchanged by these two.
- With W=5, start a write to SCRATCH[1]=0xFFFFFFFF and drop PSEL at N+2 → no PREADY, SCRATCH[1] and WCOUNT unchanged; the next transfer completes normally at N'+5.
- Assert HRESETn low during a W=3 write to 0x10 → no commit; all registers reset, CTRL=0; the next read completes with 0 waits.
